// File: rtl/dragon_pursuit_engine.sv
// ============================================================================
// dragon_pursuit_engine
// ----------------------------------------------------------------------------
// Moves the dragon head one tile per movement tick on a 2^COORD_W square grid.
// A frame counter turns vsync rising edges into step requests. Each request
// runs a sample / decide / commit sequencer that picks a single move according
// to the selected mode (chase, flee, return-home, hold).
//
// Optional feature macro: DRAGON_DIAGONAL_EN
//   When defined, chase/home may step both axes in one commit while the dragon
//   is still far from the target. Flee is never diagonal.
//
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   vsync            in   frame sync, rising edge is a frame tick
//   enable           in   0 freezes the counter and ignores new ticks
//   mode             in   00 chase, 01 flee, 10 home, 11 hold
//   period           in   frames between steps minus one
//   target_pos       in   player position {x,y}
//   dragon_pos       out  current head tile {x,y}
//   dragon_direction out  00 up, 01 right, 10 down, 11 left
//   step_pulse       out  one cycle high when dragon_pos changes
//   frame_counter    out  current frame count
//   busy             out  high while the sequencer is not idle
// ============================================================================
module dragon_pursuit_engine #(
    parameter int                   COORD_W   = 4,
    parameter int                   CNT_W     = 6,
    parameter int                   STOP_DIST = 1,
    parameter logic [2*COORD_W-1:0] HOME_POS  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [CNT_W-1:0]       period,
    input  logic [2*COORD_W-1:0]   target_pos,
    output logic [2*COORD_W-1:0]   dragon_pos,
    output logic [1:0]             dragon_direction,
    output logic                   step_pulse,
    output logic [CNT_W-1:0]       frame_counter,
    output logic                   busy
);

    localparam int PW = 2 * COORD_W;
    localparam int DW = COORD_W + 2;

    localparam logic [COORD_W-1:0] C_MAX     = '1;
    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [DW-1:0]      STOP_D    = DW'(STOP_DIST);
`ifdef DRAGON_DIAGONAL_EN
    localparam logic [DW-1:0]      DIAG_D    = DW'(STOP_DIST + 1);
`endif

    localparam logic [1:0] MODE_CHASE = 2'b00;
    localparam logic [1:0] MODE_FLEE  = 2'b01;
    localparam logic [1:0] MODE_HOME  = 2'b10;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_DECIDE = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Frame tick / counter
    logic             vsync_q, vsync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             step_req;

    // Sequencer controls
    logic do_sample;
    logic do_commit;

    // Values latched in SAMPLE
    logic [1:0]                smode_q, smode_d;
    logic [COORD_W-1:0]        sx_q, sx_d, sy_q, sy_d;
    logic signed [COORD_W:0]   dx_q, dx_d, dy_q, dy_d;
    logic [COORD_W-1:0]        adx_q, adx_d, ady_q, ady_d;
    logic [DW-1:0]             dist_q, dist_d;

    // Sample-stage arithmetic
    logic [PW-1:0]             tgt;
    logic signed [COORD_W:0]   dx_c, dy_c;
    logic [COORD_W-1:0]        adx_c, ady_c;

    // Decision
    logic               move;
    logic [COORD_W-1:0] nx, ny;
    logic [1:0]         ndir;
    logic               diag;
    logic               x_ok, y_ok;
    logic               take_x;

    // Committed outputs
    logic [PW-1:0] pos_q, pos_d;
    logic [1:0]    dir_q, dir_d;
    logic          pulse_q, pulse_d;

    // ------------------------------------------------------------------------
    // Frame tick detection and step-request counter
    // ------------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default assignment at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        vsync_d  = vsync;
        tick     = enable & vsync & ~vsync_q;
        cnt_d    = cnt_q;
        step_req = 1'b0;
        if (tick) begin
            // Compare against the live period so a period change applies at once.
            if (cnt_q < period) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d    = '0;
                step_req = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer: next-state logic. A request while not idle is simply dropped;
    // the counter has already wrapped above regardless.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (step_req) state_d = S_SAMPLE;
            S_SAMPLE: state_d = S_DECIDE;
            S_DECIDE: state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Sequencer: output decode. The move is registered on the DECIDE->COMMIT
    // edge so that the new position and step_pulse are visible in COMMIT.
    always_comb begin
        busy      = (state_q != S_IDLE);
        do_sample = (state_q == S_SAMPLE);
        do_commit = (state_q == S_DECIDE);
    end

    // ------------------------------------------------------------------------
    // SAMPLE: latch mode, target and position, pre-compute the differences
    // ------------------------------------------------------------------------
    always_comb begin
        tgt   = (mode == MODE_HOME) ? HOME_POS : target_pos;
        dx_c  = $signed({1'b0, tgt[PW-1:COORD_W]}) - $signed({1'b0, pos_q[PW-1:COORD_W]});
        dy_c  = $signed({1'b0, tgt[COORD_W-1:0]})  - $signed({1'b0, pos_q[COORD_W-1:0]});
        adx_c = dx_c[COORD_W] ? COORD_W'(-dx_c) : COORD_W'(dx_c);
        ady_c = dy_c[COORD_W] ? COORD_W'(-dy_c) : COORD_W'(dy_c);

        smode_d = smode_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        adx_d   = adx_q;
        ady_d   = ady_q;
        dist_d  = dist_q;
        if (do_sample) begin
            smode_d = mode;
            sx_d    = pos_q[PW-1:COORD_W];
            sy_d    = pos_q[COORD_W-1:0];
            dx_d    = dx_c;
            dy_d    = dy_c;
            adx_d   = adx_c;
            ady_d   = ady_c;
            dist_d  = DW'(adx_c) + DW'(ady_c);
        end
    end

    // ------------------------------------------------------------------------
    // DECIDE: choose at most one move from the latched values
    // ------------------------------------------------------------------------
    always_comb begin
        move   = 1'b0;
        nx     = sx_q;
        ny     = sy_q;
        ndir   = dir_q;
        x_ok   = 1'b0;
        y_ok   = 1'b0;
        take_x = 1'b0;
`ifdef DRAGON_DIAGONAL_EN
        diag = (dx_q != '0) && (dy_q != '0) && (dist_q > DIAG_D);
`else
        diag = 1'b0;
`endif
        case (smode_q)
            MODE_CHASE, MODE_HOME: begin
                // Home keeps going until it lands exactly on HOME_POS.
                if (dist_q > ((smode_q == MODE_HOME) ? '0 : STOP_D)) begin
                    move = 1'b1;
                    if (diag) begin
                        nx   = dx_q[COORD_W] ? sx_q - C_ONE : sx_q + C_ONE;
                        ny   = dy_q[COORD_W] ? sy_q - C_ONE : sy_q + C_ONE;
                        ndir = dx_q[COORD_W] ? DIR_LEFT : DIR_RIGHT;
                    end else if (adx_q >= ady_q) begin
                        // Tie goes to x; adx > 0 is guaranteed here.
                        nx   = dx_q[COORD_W] ? sx_q - C_ONE : sx_q + C_ONE;
                        ndir = dx_q[COORD_W] ? DIR_LEFT : DIR_RIGHT;
                    end else begin
                        ny   = dy_q[COORD_W] ? sy_q - C_ONE : sy_q + C_ONE;
                        ndir = dy_q[COORD_W] ? DIR_UP : DIR_DOWN;
                    end
                end
            end
            MODE_FLEE: begin
                // Step away = opposite sign of the difference. An axis with a
                // zero difference has no "away" and is never used; an axis whose
                // away step would leave the grid is blocked.
                x_ok   = (dx_q != '0) && (dx_q[COORD_W] ? (sx_q != C_MAX) : (sx_q != '0));
                y_ok   = (dy_q != '0) && (dy_q[COORD_W] ? (sy_q != C_MAX) : (sy_q != '0));
                take_x = x_ok && ((adx_q >= ady_q) || !y_ok);
                if (take_x) begin
                    move = 1'b1;
                    nx   = dx_q[COORD_W] ? sx_q + C_ONE : sx_q - C_ONE;
                    ndir = dx_q[COORD_W] ? DIR_RIGHT : DIR_LEFT;
                end else if (y_ok) begin
                    move = 1'b1;
                    ny   = dy_q[COORD_W] ? sy_q + C_ONE : sy_q - C_ONE;
                    ndir = dy_q[COORD_W] ? DIR_DOWN : DIR_UP;
                end
            end
            default: begin
                // hold: never moves
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // COMMIT: update position/direction and pulse only on a real move
    // ------------------------------------------------------------------------
    always_comb begin
        pos_d   = pos_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        if (do_commit && move) begin
            pos_d   = {nx, ny};
            dir_d   = ndir;
            pulse_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            cnt_q   <= '0;
            smode_q <= MODE_CHASE;
            sx_q    <= '0;
            sy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            adx_q   <= '0;
            ady_q   <= '0;
            dist_q  <= '0;
            pos_q   <= HOME_POS;
            dir_q   <= DIR_UP;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync_d;
            cnt_q   <= cnt_d;
            smode_q <= smode_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            adx_q   <= adx_d;
            ady_q   <= ady_d;
            dist_q  <= dist_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
        end
    end

    assign dragon_pos       = pos_q;
    assign dragon_direction = dir_q;
    assign step_pulse       = pulse_q;
    assign frame_counter    = cnt_q;

endmodule

// File: tb/tb_dragon_pursuit_engine.sv
module tb_dragon_pursuit_engine;

    localparam int COORD_W   = 4;
    localparam int CNT_W     = 6;
    localparam int STOP_DIST = 1;
    localparam int GRID_MAX  = (1 << COORD_W) - 1;
    localparam int HOME_X    = 0;
    localparam int HOME_Y    = 0;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 vsync;
    logic                 enable;
    logic [1:0]           mode;
    logic [CNT_W-1:0]     period;
    logic [2*COORD_W-1:0] target_pos;
    logic [2*COORD_W-1:0] dragon_pos;
    logic [1:0]           dragon_direction;
    logic                 step_pulse;
    logic [CNT_W-1:0]     frame_counter;
    logic                 busy;

    dragon_pursuit_engine #(
        .COORD_W   (COORD_W),
        .CNT_W     (CNT_W),
        .STOP_DIST (STOP_DIST),
        .HOME_POS  (8'h00)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .vsync            (vsync),
        .enable           (enable),
        .mode             (mode),
        .period           (period),
        .target_pos       (target_pos),
        .dragon_pos       (dragon_pos),
        .dragon_direction (dragon_direction),
        .step_pulse       (step_pulse),
        .frame_counter    (frame_counter),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int obs_pulses = 0;

    // ------------------------------------------------------------------
    // Reference model: event timeline in edge numbers plus a move rule.
    // A request accepted at edge R samples at edge R+1, shows its move
    // after edge R+2 and the engine is free again for a request at R+4.
    // ------------------------------------------------------------------
    int edge_n   = 0;
    int req_edge = -100;
    int m_cnt    = 0;
    int m_x      = HOME_X;
    int m_y      = HOME_Y;
    int m_dir    = 0;
    bit m_pulse  = 1'b0;
    bit m_prev_vs = 1'b0;
    int s_mode, s_px, s_py, s_tx, s_ty;

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic void model_decide(input int md, input int px, input int py,
                                         input int tx, input int ty, input int cur_dir,
                                         output bit mv, output int nx, output int ny,
                                         output int dir);
        int dx, dy, adx, ady, d, stop, fx, fy;
        bit okx, oky;
        dx  = tx - px;
        dy  = ty - py;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        d   = adx + ady;
        mv  = 1'b0;
        nx  = px;
        ny  = py;
        dir = cur_dir;
        if (md == 0 || md == 2) begin
            stop = (md == 0) ? STOP_DIST : 0;
            if (d > stop) begin
                mv = 1'b1;
                if (adx >= ady) begin
                    nx  = px + sgn(dx);
                    dir = (dx > 0) ? 1 : 3;
                end else begin
                    ny  = py + sgn(dy);
                    dir = (dy > 0) ? 2 : 0;
                end
`ifdef DRAGON_DIAGONAL_EN
                if (dx != 0 && dy != 0 && d > STOP_DIST + 1) begin
                    nx  = px + sgn(dx);
                    ny  = py + sgn(dy);
                    dir = (dx > 0) ? 1 : 3;
                end
`endif
            end
        end else if (md == 1) begin
            fx  = px - sgn(dx);
            fy  = py - sgn(dy);
            okx = (dx != 0) && (fx >= 0) && (fx <= GRID_MAX);
            oky = (dy != 0) && (fy >= 0) && (fy <= GRID_MAX);
            if (okx && (adx >= ady || !oky)) begin
                mv  = 1'b1;
                nx  = fx;
                dir = (fx > px) ? 1 : 3;
            end else if (oky) begin
                mv  = 1'b1;
                ny  = fy;
                dir = (fy > py) ? 2 : 0;
            end
        end
    endfunction

    task automatic model_edge();
        bit mv;
        int nx, ny, nd;
        bit tk;
        edge_n++;
        if (reset) begin
            m_x = HOME_X; m_y = HOME_Y; m_dir = 0; m_pulse = 1'b0;
            m_cnt = 0; m_prev_vs = 1'b0; req_edge = -100;
        end else begin
            m_pulse = 1'b0;
            tk = vsync && !m_prev_vs && enable;
            m_prev_vs = vsync;
            if (edge_n == req_edge + 2) begin
                model_decide(s_mode, s_px, s_py, s_tx, s_ty, m_dir, mv, nx, ny, nd);
                if (mv) begin
                    m_x = nx; m_y = ny; m_dir = nd; m_pulse = 1'b1;
                end
            end
            if (edge_n == req_edge + 1) begin
                s_mode = int'(mode);
                s_px = m_x; s_py = m_y;
                if (mode == 2'b10) begin
                    s_tx = HOME_X; s_ty = HOME_Y;
                end else begin
                    s_tx = int'(target_pos[7:4]); s_ty = int'(target_pos[3:0]);
                end
            end
            if (tk) begin
                if (m_cnt < int'(period)) m_cnt++;
                else begin
                    m_cnt = 0;
                    if (edge_n >= req_edge + 4) req_edge = edge_n;
                end
            end
        end
    endtask

    function automatic bit model_busy();
        return (edge_n - req_edge) >= 0 && (edge_n - req_edge) <= 2;
    endfunction

    // Apply vsync for one clock (inputs change at negedge), advance model.
    task automatic drive(input logic vs);
        vsync = vs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (step_pulse === 1'b1) obs_pulses++;
    endtask

    task automatic frames(input int n, input int len);
        for (int f = 0; f < n; f++) begin
            drive(1'b1);
            for (int c = 1; c < len; c++) drive(1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0);
        drive(1'b0);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        enable = 1'b1; mode = 2'b00; period = '0; target_pos = 8'h55;
        do_reset();
        n_vec++; if (dragon_pos !== 8'h00) begin n_bad++; $display("FAIL reset_pos got=%h exp=00", dragon_pos); end
        n_vec++; if (dragon_direction !== 2'b00) begin n_bad++; $display("FAIL reset_dir got=%b exp=00", dragon_direction); end
        n_vec++; if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got=%b exp=0", step_pulse); end
        n_vec++; if (frame_counter !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_counter); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_chase_period();
        int k;
        do_reset();
        period = 6'd2; mode = 2'b00; target_pos = 8'h50; obs_pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            k = i / 3;
            drive(1'b1);
            n_vec++; if (frame_counter !== 6'(i % 3)) begin n_bad++; $display("FAIL period_cnt tick=%0d got=%0d exp=%0d", i, frame_counter, i % 3); end
            drive(1'b0);
            n_vec++; if (step_pulse !== 1'b0) begin n_bad++; $display("FAIL period_early_pulse tick=%0d got=%b exp=0", i, step_pulse); end
            drive(1'b0);
            n_vec++; if (step_pulse !== ((i % 3) == 0)) begin n_bad++; $display("FAIL period_pulse tick=%0d got=%b exp=%b", i, step_pulse, (i % 3) == 0); end
            n_vec++; if (dragon_pos !== {4'(k), 4'h0}) begin n_bad++; $display("FAIL period_pos tick=%0d got=%h exp=%h", i, dragon_pos, {4'(k), 4'h0}); end
            drive(1'b0);
        end
        n_vec++; if (dragon_direction !== 2'b01) begin n_bad++; $display("FAIL period_dir got=%b exp=01", dragon_direction); end
        n_vec++; if (obs_pulses != 3) begin n_bad++; $display("FAIL period_pulse_count got=%0d exp=3", obs_pulses); end
    endtask

    task automatic test_chase_stop();
        do_reset();
        period = '0; mode = 2'b00; target_pos = 8'h45;
        frames(10, 5);
        n_vec++; if (dragon_pos !== 8'h44) begin n_bad++; $display("FAIL stop_reach got=%h exp=44", dragon_pos); end
        obs_pulses = 0;
        frames(5, 5);
        n_vec++; if (obs_pulses != 0) begin n_bad++; $display("FAIL stop_pulses got=%0d exp=0", obs_pulses); end
        n_vec++; if (dragon_pos !== 8'h44) begin n_bad++; $display("FAIL stop_hold got=%h exp=44", dragon_pos); end
    endtask

    task automatic test_tie_priority();
        do_reset();
        period = '0; mode = 2'b00; target_pos = 8'h22;
        frames(1, 5);
        n_vec++; if (dragon_pos !== 8'h10) begin n_bad++; $display("FAIL tie_pos got=%h exp=10", dragon_pos); end
        n_vec++; if (dragon_direction !== 2'b01) begin n_bad++; $display("FAIL tie_dir got=%b exp=01", dragon_direction); end
        target_pos = 8'h19;
        frames(1, 5);
        n_vec++; if (dragon_pos !== 8'h11) begin n_bad++; $display("FAIL ypri_pos got=%h exp=11", dragon_pos); end
        n_vec++; if (dragon_direction !== 2'b10) begin n_bad++; $display("FAIL ypri_dir got=%b exp=10", dragon_direction); end
    endtask

    task automatic test_flee_corner();
        period = '0; mode = 2'b00; target_pos = 8'hFF;
        frames(32, 5);
        mode = 2'b01; target_pos = 8'h00;
        frames(1, 5);
        n_vec++; if (dragon_pos !== 8'hFF) begin n_bad++; $display("FAIL flee_to_corner got=%h exp=ff", dragon_pos); end
        n_vec++; if (dragon_direction !== 2'b10) begin n_bad++; $display("FAIL flee_dir got=%b exp=10", dragon_direction); end
        target_pos = 8'hEE; obs_pulses = 0;
        frames(3, 5);
        n_vec++; if (obs_pulses != 0 || dragon_pos !== 8'hFF) begin n_bad++; $display("FAIL flee_both_blocked pulses=%0d pos=%h exp 0/ff", obs_pulses, dragon_pos); end
        target_pos = 8'hEF; obs_pulses = 0;
        frames(3, 5);
        n_vec++; if (obs_pulses != 0 || dragon_pos !== 8'hFF) begin n_bad++; $display("FAIL flee_y_blocked pulses=%0d pos=%h exp 0/ff", obs_pulses, dragon_pos); end
    endtask

    task automatic test_home_reset();
        do_reset();
        period = '0; mode = 2'b00; target_pos = 8'h40;
        frames(5, 5);
        n_vec++; if (dragon_pos !== 8'h30) begin n_bad++; $display("FAIL home_setup got=%h exp=30", dragon_pos); end
        mode = 2'b10; target_pos = 8'hA7; obs_pulses = 0;
        frames(4, 5);
        n_vec++; if (dragon_pos !== 8'h00) begin n_bad++; $display("FAIL home_pos got=%h exp=00", dragon_pos); end
        n_vec++; if (dragon_direction !== 2'b11) begin n_bad++; $display("FAIL home_dir got=%b exp=11", dragon_direction); end
        n_vec++; if (obs_pulses != 3) begin n_bad++; $display("FAIL home_steps got=%0d exp=3", obs_pulses); end
        mode = 2'b00; target_pos = 8'h50;
        frames(1, 5);
        drive(1'b1);
        drive(1'b0);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midstep_busy got=%b exp=1", busy); end
        reset = 1'b1;
        drive(1'b0);
        reset = 1'b0;
        n_vec++; if (dragon_pos !== 8'h00 || busy !== 1'b0 || step_pulse !== 1'b0) begin
            n_bad++; $display("FAIL midstep_reset pos=%h busy=%b pulse=%b exp 00/0/0", dragon_pos, busy, step_pulse);
        end
    endtask

    task automatic test_busy_drop_enable();
        do_reset();
        period = '0; mode = 2'b00; target_pos = 8'h90; obs_pulses = 0;
        drive(1'b1); drive(1'b0); drive(1'b1);
        for (int c = 0; c < 6; c++) drive(1'b0);
        n_vec++; if (obs_pulses != 1) begin n_bad++; $display("FAIL drop_pulses got=%0d exp=1", obs_pulses); end
        n_vec++; if (dragon_pos !== 8'h10) begin n_bad++; $display("FAIL drop_pos got=%h exp=10", dragon_pos); end
        n_vec++; if (frame_counter !== '0) begin n_bad++; $display("FAIL drop_cnt got=%0d exp=0", frame_counter); end
        period = 6'd3;
        frames(2, 4);
        n_vec++; if (frame_counter !== 6'd2) begin n_bad++; $display("FAIL en_cnt_pre got=%0d exp=2", frame_counter); end
        enable = 1'b0; obs_pulses = 0;
        frames(6, 4);
        n_vec++; if (frame_counter !== 6'd2) begin n_bad++; $display("FAIL en_frozen got=%0d exp=2", frame_counter); end
        n_vec++; if (obs_pulses != 0 || dragon_pos !== 8'h10) begin n_bad++; $display("FAIL en_nostep pulses=%0d pos=%h exp 0/10", obs_pulses, dragon_pos); end
        enable = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) target_pos = 8'($urandom);
            if ($urandom_range(0, 29) == 0) period = 6'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 399) == 0);
            drive(1'($urandom_range(0, 1)));
            n_vec++;
            if (dragon_pos !== {4'(m_x), 4'(m_y)} || dragon_direction !== 2'(m_dir) ||
                step_pulse !== m_pulse || frame_counter !== 6'(m_cnt) || busy !== model_busy()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got pos=%h dir=%0d pulse=%b cnt=%0d busy=%b exp pos=%h dir=%0d pulse=%b cnt=%0d busy=%b",
                         c, dragon_pos, dragon_direction, step_pulse, frame_counter, busy,
                         {4'(m_x), 4'(m_y)}, m_dir, m_pulse, m_cnt, model_busy());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; enable = 1'b1; mode = 2'b00;
        period = '0; target_pos = '0;
        @(negedge clk);
        test_reset();
        test_chase_period();
        test_chase_stop();
        test_tie_priority();
        test_flee_corner();
        test_home_reset();
        test_busy_drop_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
